// File: rtl/ddr_req_arbiter.sv
// Two-requestor (fetch / LSU) arbiter in front of a single-outstanding DDR port.
// Optional WAIT-state watchdog is compiled in with `define DDR_ARB_TIMEOUT_EN.
module ddr_req_arbiter (
    input  logic         clock,
    input  logic         reset_n,
    // instruction fetch requestor
    input  logic         pc_read_req,
    input  logic [63:0]  pc_read_addr,
    input  logic         pc_flush,
    output logic         pc_read_ack,
    output logic [511:0] pc_read_inst,
    // load/store requestor
    input  logic         lsu_req,
    input  logic         lsu_write,
    input  logic [63:0]  lsu_addr,
    input  logic [63:0]  lsu_wmask,
    input  logic [63:0]  lsu_wdata,
    output logic         lsu_ack,
    output logic [63:0]  lsu_rdata,
    // DDR side
    output logic         ddr_chip_enable,
    output logic [18:0]  ddr_index,
    output logic         ddr_write_enable,
    output logic         ddr_burst_mode,
    output logic [63:0]  ddr_opstore_write_mask,
    output logic [63:0]  ddr_opstore_write_data,
    input  logic [63:0]  ddr_opload_read_data,
    input  logic [511:0] ddr_pc_read_inst,
    input  logic         ddr_operation_done,
    input  logic         ddr_ready,
    output logic         ddr_timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t r_state;
    logic   r_last_fetch;   // 1 = fetch held the most recent grant
    logic   r_gnt_fetch;    // operation in flight belongs to fetch
    logic   r_drop;         // in-flight fetch was flushed; swallow its response

    logic   w_fetch_ok;
    logic   w_grant_lsu;
    logic   w_grant_fetch;
    logic   w_drop_now;
    logic   w_timeout;
    logic   w_unused;

    // A flush in IDLE only blocks the fetch grant for that cycle.
    assign w_fetch_ok    = pc_read_req & ~pc_flush;
    assign w_grant_lsu   = ddr_ready & lsu_req & (~w_fetch_ok | r_last_fetch);
    assign w_grant_fetch = ddr_ready & w_fetch_ok & ~w_grant_lsu;
    assign w_drop_now    = r_drop | (r_gnt_fetch & pc_flush);

    assign w_unused = ^{pc_read_addr[63:22], pc_read_addr[5:0],
                        lsu_addr[63:22], lsu_addr[2:0]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state                <= ST_IDLE;
            r_last_fetch           <= 1'b1;
            r_gnt_fetch            <= 1'b0;
            r_drop                 <= 1'b0;
            pc_read_ack            <= 1'b0;
            pc_read_inst           <= '0;
            lsu_ack                <= 1'b0;
            lsu_rdata              <= '0;
            ddr_chip_enable        <= 1'b0;
            ddr_index              <= '0;
            ddr_write_enable       <= 1'b0;
            ddr_burst_mode         <= 1'b0;
            ddr_opstore_write_mask <= '0;
            ddr_opstore_write_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    pc_read_ack <= 1'b0;
                    lsu_ack     <= 1'b0;
                    if (w_grant_lsu) begin
                        r_state                <= ST_ISSUE;
                        r_gnt_fetch            <= 1'b0;
                        r_last_fetch           <= 1'b0;
                        ddr_chip_enable        <= 1'b1;
                        ddr_index              <= lsu_addr[21:3];
                        ddr_write_enable       <= lsu_write;
                        ddr_burst_mode         <= 1'b0;
                        ddr_opstore_write_mask <= lsu_wmask;
                        ddr_opstore_write_data <= lsu_wdata;
                    end else if (w_grant_fetch) begin
                        r_state                <= ST_ISSUE;
                        r_gnt_fetch            <= 1'b1;
                        r_last_fetch           <= 1'b1;
                        ddr_chip_enable        <= 1'b1;
                        ddr_index              <= {pc_read_addr[21:6], 3'b000};
                        ddr_write_enable       <= 1'b0;
                        ddr_burst_mode         <= 1'b1;
                        ddr_opstore_write_mask <= '0;
                        ddr_opstore_write_data <= '0;
                    end
                end

                ST_ISSUE: begin
                    ddr_chip_enable <= 1'b0;
                    r_drop          <= w_drop_now;
                    r_state         <= ST_WAIT;
                end

                ST_WAIT: begin
                    r_drop <= w_drop_now;
                    if (ddr_operation_done || w_timeout) begin
                        r_state <= ST_RESP;
                        // Timeout completes the request with zero data.
                        if (r_gnt_fetch) begin
                            if (!w_drop_now) begin
                                pc_read_ack  <= 1'b1;
                                pc_read_inst <= w_timeout ? '0 : ddr_pc_read_inst;
                            end
                        end else begin
                            lsu_ack <= 1'b1;
                            if (w_timeout) begin
                                lsu_rdata <= '0;
                            end else if (!ddr_write_enable) begin
                                lsu_rdata <= ddr_opload_read_data;
                            end
                        end
                    end
                end

                ST_RESP: begin
                    pc_read_ack <= 1'b0;
                    lsu_ack     <= 1'b0;
                    r_drop      <= 1'b0;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DDR_ARB_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       r_timeout_err;

    // Fires on the 255th WAIT cycle that has not seen ddr_operation_done.
    assign w_timeout = (r_state == ST_WAIT) && !ddr_operation_done &&
                       (r_wait_cnt == 8'd254);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != ST_WAIT) begin
                r_wait_cnt <= '0;
            end else if (!ddr_operation_done) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign ddr_timeout_err = r_timeout_err;
`else
    assign w_timeout       = 1'b0;
    assign ddr_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed bench for ddr_req_arbiter with a small behavioural DDR model.
// Timeout scenario runs only when DDR_ARB_TIMEOUT_EN is defined.
module tb_ddr_req_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pc_read_req = 1'b0;
    logic [63:0]  pc_read_addr = '0;
    logic         pc_flush = 1'b0;
    logic         pc_read_ack;
    logic [511:0] pc_read_inst;
    logic         lsu_req = 1'b0;
    logic         lsu_write = 1'b0;
    logic [63:0]  lsu_addr = '0;
    logic [63:0]  lsu_wmask = '0;
    logic [63:0]  lsu_wdata = '0;
    logic         lsu_ack;
    logic [63:0]  lsu_rdata;
    logic         ddr_chip_enable;
    logic [18:0]  ddr_index;
    logic         ddr_write_enable;
    logic         ddr_burst_mode;
    logic [63:0]  ddr_opstore_write_mask;
    logic [63:0]  ddr_opstore_write_data;
    logic [63:0]  ddr_opload_read_data = '0;
    logic [511:0] ddr_pc_read_inst = '0;
    logic         ddr_operation_done = 1'b0;
    logic         ddr_ready = 1'b1;
    logic         ddr_timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ddr_req_arbiter dut (
        .clock                  (clk),
        .reset_n                (rst_n),
        .pc_read_req            (pc_read_req),
        .pc_read_addr           (pc_read_addr),
        .pc_flush               (pc_flush),
        .pc_read_ack            (pc_read_ack),
        .pc_read_inst           (pc_read_inst),
        .lsu_req                (lsu_req),
        .lsu_write              (lsu_write),
        .lsu_addr               (lsu_addr),
        .lsu_wmask              (lsu_wmask),
        .lsu_wdata              (lsu_wdata),
        .lsu_ack                (lsu_ack),
        .lsu_rdata              (lsu_rdata),
        .ddr_chip_enable        (ddr_chip_enable),
        .ddr_index              (ddr_index),
        .ddr_write_enable       (ddr_write_enable),
        .ddr_burst_mode         (ddr_burst_mode),
        .ddr_opstore_write_mask (ddr_opstore_write_mask),
        .ddr_opstore_write_data (ddr_opstore_write_data),
        .ddr_opload_read_data   (ddr_opload_read_data),
        .ddr_pc_read_inst       (ddr_pc_read_inst),
        .ddr_operation_done     (ddr_operation_done),
        .ddr_ready              (ddr_ready),
        .ddr_timeout_err        (ddr_timeout_err)
    );

    function automatic logic [63:0] word_init(input int i);
        return 64'hC0DE_0000_0000_0000 + 64'(i);
    endfunction

    function automatic logic [511:0] line_at(input int base);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = word_init(base + k);
        return l;
    endfunction

    // DDR model: completes three cycles after the chip-enable cycle unless held.
    logic [63:0] mem [0:1023];
    logic        hold_done = 1'b0;
    logic        m_busy = 1'b0;
    logic [1:0]  m_cnt = '0;
    logic [18:0] m_idx = '0;
    logic        m_we = 1'b0;
    logic        m_burst = 1'b0;
    logic [63:0] m_mask = '0;
    logic [63:0] m_data = '0;

    initial for (int i = 0; i < 1024; i++) mem[i] = word_init(i);

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy             <= 1'b0;
            ddr_operation_done <= 1'b0;
        end else begin
            ddr_operation_done <= 1'b0;
            if (ddr_chip_enable) begin
                m_busy  <= 1'b1;
                m_cnt   <= 2'd2;
                m_idx   <= ddr_index;
                m_we    <= ddr_write_enable;
                m_burst <= ddr_burst_mode;
                m_mask  <= ddr_opstore_write_mask;
                m_data  <= ddr_opstore_write_data;
            end else if (m_busy && !hold_done) begin
                if (m_cnt != 2'd0) begin
                    m_cnt <= m_cnt - 2'd1;
                end else begin
                    m_busy             <= 1'b0;
                    ddr_operation_done <= 1'b1;
                    if (m_burst) begin
                        for (int k = 0; k < 8; k++)
                            ddr_pc_read_inst[64*k +: 64] <= mem[m_idx[9:0] + 10'(k)];
                    end else if (m_we) begin
                        mem[m_idx[9:0]] <= (mem[m_idx[9:0]] & ~m_mask) | (m_data & m_mask);
                    end else begin
                        ddr_opload_read_data <= mem[m_idx[9:0]];
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ce"}, ddr_chip_enable, 0);
        chk({tag, "_idx"}, ddr_index, 0);
        chk({tag, "_we"}, ddr_write_enable, 0);
        chk({tag, "_burst"}, ddr_burst_mode, 0);
        chk({tag, "_acks"}, {pc_read_ack, lsu_ack}, 0);
        chk({tag, "_rdata"}, lsu_rdata, 0);
        chk({tag, "_inst"}, pc_read_inst, 0);
        chk({tag, "_err"}, ddr_timeout_err, 0);
    endtask

    task automatic wait_ce(input string tag);
        int n = 0;
        while (ddr_chip_enable !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ce_seen"}, ddr_chip_enable, 1);
    endtask

    task automatic wait_done(input string tag, input logic [18:0] idx,
                             input logic we, input logic burst);
        int n = 0;
        int bad = 0;
        while (ddr_operation_done !== 1'b1 && n < 100) begin
            if (ddr_index !== idx || ddr_write_enable !== we ||
                ddr_burst_mode !== burst || ddr_chip_enable !== 1'b0) bad++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, ddr_operation_done, 1);
        chk({tag, "_held"}, bad, 0);
    endtask

    // Called at the negedge where chip_enable is first seen high.
    task automatic finish_lsu(input string tag, input logic wr, input logic [18:0] idx,
                              input logic [63:0] exp_rdata, input logic keep_req);
        chk({tag, "_idx"}, ddr_index, idx);
        chk({tag, "_burst"}, ddr_burst_mode, 0);
        chk({tag, "_we"}, ddr_write_enable, wr);
        @(negedge clk);
        chk({tag, "_ce_pulse"}, ddr_chip_enable, 0);
        wait_done(tag, idx, wr, 1'b0);
        chk({tag, "_ack_early"}, lsu_ack, 0);
        @(negedge clk);
        chk({tag, "_ack"}, lsu_ack, 1);
        chk({tag, "_rdata"}, lsu_rdata, exp_rdata);
        if (!keep_req) lsu_req = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_pulse"}, lsu_ack, 0);
        $display("TXN %s lsu we=%0d idx=%05h rdata=%016h", tag, wr, idx, lsu_rdata);
    endtask

    task automatic finish_fetch(input string tag, input logic [18:0] idx,
                                input logic [511:0] exp_line, input logic flush);
        chk({tag, "_idx"}, ddr_index, idx);
        chk({tag, "_burst"}, ddr_burst_mode, 1);
        chk({tag, "_we"}, ddr_write_enable, 0);
        @(negedge clk);
        chk({tag, "_ce_pulse"}, ddr_chip_enable, 0);
        if (flush) begin
            pc_flush    = 1'b1;
            pc_read_req = 1'b0;
            @(negedge clk);
            pc_flush = 1'b0;
        end
        wait_done(tag, idx, 1'b0, 1'b1);
        chk({tag, "_ack_early"}, pc_read_ack, 0);
        @(negedge clk);
        chk({tag, "_ack"}, pc_read_ack, !flush);
        chk({tag, "_inst"}, pc_read_inst, exp_line);
        pc_read_req = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_pulse"}, pc_read_ack, 0);
        $display("TXN %s fetch idx=%05h flush=%0d", tag, idx, flush);
    endtask

    task automatic lsu_txn(input string tag, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] wmask,
                           input logic [18:0] idx, input logic [63:0] exp_rdata);
        lsu_req   = 1'b1;
        lsu_write = wr;
        lsu_addr  = addr;
        lsu_wdata = wdata;
        lsu_wmask = wmask;
        wait_ce(tag);
        if (wr) begin
            chk({tag, "_wdata"}, ddr_opstore_write_data, wdata);
            chk({tag, "_wmask"}, ddr_opstore_write_mask, wmask);
        end
        finish_lsu(tag, wr, idx, exp_rdata, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        logic err_before;

        // Reset state
        @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // LSU load, fetch, store
        lsu_txn("load", 1'b0, 64'h8000_0010, '0, '0, 19'h00002, word_init(2));
        pc_read_req  = 1'b1;
        pc_read_addr = 64'h8000_1048;
        wait_ce("fetch");
        finish_fetch("fetch", 19'h00208, line_at(32'h208), 1'b0);
        lsu_txn("store", 1'b1, 64'h18, 64'hDEAD_BEEF, '1, 19'h00003, word_init(2));
        chk("store_mem", mem[3], 64'hDEAD_BEEF);

        // Flushed fetch: no ack, line unchanged; LSU afterwards is normal
        pc_read_req  = 1'b1;
        pc_read_addr = 64'h40;
        wait_ce("flush");
        finish_fetch("flush", 19'h00008, line_at(32'h208), 1'b1);
        lsu_txn("postflush", 1'b0, 64'h28, '0, '0, 19'h00005, word_init(5));

        // Simultaneous requests after reset, DDR initially not ready
        do_reset();
        ddr_ready    = 1'b0;
        lsu_req      = 1'b1;
        lsu_write    = 1'b0;
        lsu_addr     = 64'h20;
        pc_read_req  = 1'b1;
        pc_read_addr = 64'h40;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ddr_chip_enable) cnt++;
        end
        chk("notready_ce", cnt, 0);
        ddr_ready = 1'b1;
        wait_ce("tie_lsu");
        finish_lsu("tie_lsu", 1'b0, 19'h00004, word_init(4), 1'b1);
        wait_ce("tie_fetch");
        finish_fetch("tie_fetch", 19'h00008, line_at(8), 1'b0);
        wait_ce("tie_lsu2");
        finish_lsu("tie_lsu2", 1'b0, 19'h00004, word_init(4), 1'b0);

        // Reset while waiting on DDR
        hold_done = 1'b1;
        lsu_req   = 1'b1;
        lsu_addr  = 64'h8000_0010;
        wait_ce("midrst");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        lsu_req = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        hold_done = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (lsu_ack || pc_read_ack || ddr_chip_enable) cnt++;
        end
        chk("midrst_quiet", cnt, 0);
        $display("TXN midrst abandoned");

`ifdef DDR_ARB_TIMEOUT_EN
        lsu_txn("to_pre", 1'b0, 64'h10, '0, '0, 19'h00002, word_init(2));
        hold_done  = 1'b1;
        lsu_req    = 1'b1;
        lsu_addr   = 64'h10;
        wait_ce("timeout");
        cnt        = 0;
        err_before = 1'b1;
        while (lsu_ack !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (cnt == 255) err_before = ddr_timeout_err;
        end
        chk("timeout_lat", cnt, 256);
        chk("timeout_err_early", err_before, 0);
        chk("timeout_ack", lsu_ack, 1);
        chk("timeout_err", ddr_timeout_err, 1);
        chk("timeout_rdata", lsu_rdata, 0);
        lsu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("timeout_ack_pulse", lsu_ack, 0);
        chk("timeout_sticky", ddr_timeout_err, 1);
        $display("TXN timeout after %0d cycles", cnt);
`else
        err_before = 1'b0;
        chk("noto_err", ddr_timeout_err, err_before);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
